// File: rtl/palette_access_arbiter.sv
// Posted-write FIFO and slot sequencer for the shared palette RAM (CPU vs pixel lookup).
// Latency: write ack 1 clk after cs; read data 2 RAM slots after FIFO drains in a free slot.
// Backpressure: writes stall (dtackn high) while the FIFO is full; reads stall until drained and free.

// Small synchronous FIFO with head-of-queue visibility and occupancy count.
// Latency: pushed data visible at the head 1 clk after the push.
// Backpressure: pushes are ignored while full; pops are ignored while empty.
module palette_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_vld,
  input  logic [W-1:0]             in_dat,
  output logic                     full,
  input  logic                     out_rdy,
  output logic                     out_vld,
  output logic [W-1:0]             out_dat,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(DEPTH));
  assign out_vld = (level != '0);
  assign out_dat = mem[rd_ptr];
  assign do_push = in_vld & ~full;
  assign do_pop  = out_rdy & out_vld;

  // Storage needs no reset: pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= in_dat;
  end

  // Pointers wrap modulo DEPTH; level moves only when exactly one of push/pop fires.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end
endmodule

module palette_access_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 14
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ce_pixel,
  input  logic                   ce_double,
  input  logic                   HBLANKn,
  input  logic                   VBLANKn,
  input  logic                   ACCMODE,
  input  logic                   cpu_cs,
  input  logic [AW-1:0]          cpu_a,
  input  logic [15:0]            cpu_din,
  input  logic                   cpu_rwn,
  input  logic                   cpu_udsn,
  input  logic                   cpu_ldsn,
  output logic [15:0]            cpu_dout,
  output logic                   cpu_dtackn,
  input  logic [AW-1:0]          vid_idx,
  output logic [15:0]            vid_data,
  output logic                   vid_valid,
  output logic [AW-1:0]          ram_addr,
  input  logic [15:0]            ram_din,
  output logic [15:0]            ram_dout,
  output logic                   ram_wehn,
  output logic                   ram_weln,
  output logic [$clog2(DEPTH):0] fifo_level
);
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   dat;
    logic          ub;
    logic          lb;
  } wr_ent_t;

  typedef enum logic [2:0] {IDLE, WR_ACK, RD_WAIT, RD_ISSUE, RD_ACK} state_t;

  state_t  state;
  state_t  state_nxt;
  wr_ent_t push_ent;
  wr_ent_t head_ent;
  logic    free;
  logic    fifo_push;
  logic    fifo_pop;
  logic    fifo_full;
  logic    fifo_nempty;
  logic    rd_go;
  logic    slot_vid;

  // CPU may own a RAM slot during either blank or when the override is set.
  assign free     = ACCMODE | ~HBLANKn | ~VBLANKn;
  assign push_ent = '{addr: cpu_a, dat: cpu_din, ub: ~cpu_udsn, lb: ~cpu_ldsn};
  // A slot that completes a read is left to video, so commits never collide with it.
  assign fifo_pop = ce_double & free & fifo_nempty & (state != RD_ISSUE);

  palette_fifo #(
    .W     ($bits(wr_ent_t)),
    .DEPTH (DEPTH)
  ) u_wr_fifo (
    .clk     (clk),
    .reset   (reset),
    .in_vld  (fifo_push),
    .in_dat  (push_ent),
    .full    (fifo_full),
    .out_rdy (fifo_pop),
    .out_vld (fifo_nempty),
    .out_dat (head_ent),
    .level   (fifo_level)
  );

  // Next-state logic: accept writes into the FIFO, hold reads until the FIFO drains in a free slot.
  always_comb begin
    state_nxt = state;
    fifo_push = 1'b0;
    rd_go     = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_cs & ~cpu_rwn & ~fifo_full) begin
          state_nxt = WR_ACK;
          fifo_push = ~cpu_udsn | ~cpu_ldsn;
        end else if (cpu_cs & cpu_rwn) begin
          state_nxt = RD_WAIT;
        end
      end
      WR_ACK: begin
        if (~cpu_cs) state_nxt = IDLE;
      end
      RD_WAIT: begin
        if (~cpu_cs) begin
          state_nxt = IDLE;
        end else if (ce_double & free & ~fifo_nempty) begin
          state_nxt = RD_ISSUE;
          rd_go     = 1'b1;
        end
      end
      RD_ISSUE: begin
        if (ce_double) state_nxt = cpu_cs ? RD_ACK : IDLE;
      end
      RD_ACK: begin
        if (~cpu_cs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; dtack is registered so it follows acceptance by one clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cpu_dtackn <= 1'b1;
    end else begin
      state      <= state_nxt;
      cpu_dtackn <= ~((state_nxt == WR_ACK) | (state_nxt == RD_ACK));
    end
  end

  // Capture read data one slot after the read address was presented.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_dout <= '0;
    end else if (ce_double && (state == RD_ISSUE)) begin
      cpu_dout <= ram_din;
    end
  end

  // Per-slot RAM port owner: commit, then CPU read, otherwise pixel lookup.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_addr <= '0;
      ram_dout <= '0;
      ram_wehn <= 1'b1;
      ram_weln <= 1'b1;
      slot_vid <= 1'b0;
    end else if (ce_double) begin
      if (fifo_pop) begin
        ram_addr <= head_ent.addr;
        ram_dout <= head_ent.dat;
        ram_wehn <= ~head_ent.ub;
        ram_weln <= ~head_ent.lb;
        slot_vid <= 1'b0;
      end else if (rd_go) begin
        ram_addr <= cpu_a;
        ram_wehn <= 1'b1;
        ram_weln <= 1'b1;
        slot_vid <= 1'b0;
      end else begin
        ram_addr <= vid_idx;
        ram_wehn <= 1'b1;
        ram_weln <= 1'b1;
        slot_vid <= 1'b1;
      end
    end
  end

  // Pixel output: blank the pixel whose slot was stolen by the CPU.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vid_data  <= '0;
      vid_valid <= 1'b0;
    end else if (ce_pixel) begin
      vid_valid <= slot_vid;
      vid_data  <= slot_vid ? ram_din : 16'h0000;
    end
  end
endmodule

// File: doc/palette_access_arbiter.md
Name: palette_access_arbiter

Overview:
- Sequences access to the shared 16-bit palette RAM between the 68000 CPU bus and the pixel lookup path.
- CPU writes are posted into a small FIFO and acknowledged immediately. They are committed to RAM only in blanking, or at any time when the access-mode override is set.
- CPU reads are stalled until the FIFO is drained and a free slot exists.
- Sits between the CPU bus decode and the palette RAM, ahead of the colour DAC stage.

Parameters:
- DEPTH, 4, number of posted-write FIFO entries (power of 2, ≥2).
- AW, 14, palette RAM word address width.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- ce_pixel  in  1  pixel clock enable.
- ce_double  in  1  RAM slot enable (2x pixel rate).
- HBLANKn  in  1  horizontal blank, active low.
- VBLANKn  in  1  vertical blank, active low.
- ACCMODE  in  1  1 = CPU may commit in any slot.
- cpu_cs  in  1  palette chip select.
- cpu_a  in  AW  CPU word address.
- cpu_din  in  16  CPU write data.
- cpu_rwn  in  1  1 = read.
- cpu_udsn  in  1  upper data strobe, active low.
- cpu_ldsn  in  1  lower data strobe, active low.
- cpu_dout  out  16  read data.
- cpu_dtackn  out  1  acknowledge, active low.
- vid_idx  in  AW  pixel palette index.
- vid_data  out  16  palette word for the pixel.
- vid_valid  out  1  0 = slot used by CPU, pixel must be blanked.
- ram_addr  out  AW  RAM address.
- ram_din  in  16  RAM read data; 1-slot latency.
- ram_dout  out  16  RAM write data.
- ram_wehn  out  1  upper-byte write enable, active low.
- ram_weln  out  1  lower-byte write enable, active low.
- fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- **Reset values:** cpu_dtackn=1, cpu_dout=0, ram_wehn=ram_weln=1, ram_addr=0, ram_dout=0, vid_data=0, vid_valid=0, fifo_level=0, FIFO emptied, FSM=IDLE. A reset mid-transaction discards all posted writes.
- **Free slot:** `free` = ACCMODE | ~HBLANKn | ~VBLANKn, sampled on ce_double.
- **FSM states:** IDLE, WR_ACK, RD_WAIT, RD_ISSUE, RD_ACK.
- **IDLE → WR_ACK (write):** taken on cpu_cs & ~cpu_rwn & FIFO not full.
  - Pushes {cpu_a, cpu_din, ~cpu_udsn, ~cpu_ldsn} in the same clk.
  - If both strobes are high, nothing is pushed but the write is still acknowledged.
  - If the FIFO is full, the FSM stays in IDLE and dtackn stays 1.
- **IDLE → RD_WAIT (read):** taken on cpu_cs & cpu_rwn.
- **WR_ACK:** cpu_dtackn=0, registered one clk after acceptance. Held until cpu_cs=0, then → IDLE with cpu_dtackn=1.
- **RD_WAIT → RD_ISSUE:** on a ce_double with FIFO empty and free. In that slot ram_addr=cpu_a and the write enables are high.
- **RD_ISSUE → RD_ACK:** on the next ce_double, cpu_dout<=ram_din.
- **RD_ACK:** cpu_dtackn=0 until cpu_cs=0, then → IDLE.
- **Read coherency:** reads therefore always observe every earlier posted write.
- **Commit:** on ce_double, when free & FIFO not empty & FSM≠RD_ISSUE, pop the head entry.
  - Drive ram_addr/ram_dout from the entry; ram_wehn/ram_weln = inverted strobe bits.
  - These outputs are registered and held for exactly one ce_double period.
  - Commits are strictly in FIFO order; at most one per slot.
- **Simultaneous events:** push and pop in the same clk leave fifo_level unchanged. A pop of the last entry in the same slot as a read request delays the read issue by one slot.
- **Video slot:** on a ce_double not used by a commit or read, ram_addr<=vid_idx and the write enables stay high. On ce_pixel, vid_data<=ram_din and vid_valid<=1 if the previous slot was video, else vid_valid<=0 and vid_data<=0.
- **CPU drops cs early:** cpu_cs falling in RD_WAIT → IDLE with no RAM access. In RD_ISSUE the FSM completes the access, then returns to IDLE without asserting dtack.
- **Pointers:** FIFO pointers wrap modulo DEPTH. fifo_level saturates logically at DEPTH and never exceeds it.

Test Plan:
- **Posted write in active display:** ACCMODE=0, HBLANKn=VBLANKn=1, write 0x7C1F to 0x0010 with both strobes.
  - dtackn=0 one clk after cs; fifo_level=1; no RAM write.
  - At the first ce_double after HBLANKn=0: ram_addr=0x0010, ram_dout=0x7C1F, both write enables low for one slot; fifo_level=0.
- **Full FIFO:** DEPTH=4, five writes during active display. Writes 1–4 are acked. Write 5 holds dtackn=1 until a blanking commit drains one entry, then is acked; fifo_level=4.
- **Read after write:** post 0x1234 at 0x0020, then read 0x0020 during blank. The read issues only after the commit; cpu_dout=0x1234, dtackn=0.
- **Byte writes:** RAM word=0xFFFF, write 0x00AB with udsn=1, ldsn=0. Only ram_weln=0 pulses; RAM reads back 0xFFAB.
- **ACCMODE=1:** a write in active display commits on the next ce_double. That pixel gets vid_valid=0 and vid_data=0.
- **Reset mid-operation:** three writes posted, then reset asserted for one clk. fifo_level=0, dtackn=1, write enables stay high through the following blanking period.
